arbiter_rr4_4ph: RTL and testbench

ARBITER_RR4_4PH -- requirements
Module: arbiter_rr4_4ph

---
 rtl/arbiter_4ph_pkg.sv | 22 ++
 rtl/sync_ff.sv | 27 ++
 rtl/arbiter_rr4_4ph.sv | 168 ++++++++++++++++
 tb/tb_arbiter_rr4_4ph.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arbiter_4ph_pkg.sv
// Shared definitions for the 4-phase round-robin arbiter.
//   state_t          : FSM state encoding (IDLE, REQ, GRANT, RELEASE)
//   DEF_N            : default number of requester channels
//   DEF_SYNC_STAGES  : default synchronizer depth
//   idx_w()          : width of a channel index for n channels
package arbiter_4ph_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_GRANT   = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam int DEF_N           = 4;
    localparam int DEF_SYNC_STAGES = 2;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchronizer with asynchronous active-low clear.
//   clk  : destination clock
//   rstn : asynchronous active-low clear of every stage
//   d    : asynchronous input
//   q    : synchronized output, STAGES rising edges after d
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_p;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            chain_p <= '0;
        end else begin
            chain_p <= {chain_p[STAGES-2:0], d};
        end
    end

    assign q = chain_p[STAGES-1];

endmodule

// File: rtl/arbiter_rr4_4ph.sv
// Round-robin arbiter between N 4-phase requesters and one 4-phase resource.
//   clk    : single clock, rising edge
//   rstn   : asynchronous active-low reset
//   r      : per-requester 4-phase requests (asynchronous)
//   a      : per-requester 4-phase acknowledges (registered, at most one high)
//   r0     : request to the shared resource (registered)
//   a0     : acknowledge from the shared resource (asynchronous)
//   gnt_id : index of the current or most recent winner (registered)
//   busy   : high whenever the FSM is not in IDLE
//   err    : sticky protocol-violation flag, cleared only by reset
module arbiter_rr4_4ph
    import arbiter_4ph_pkg::*;
#(
    parameter int N           = DEF_N,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [N-1:0]          r,
    output logic [N-1:0]          a,
    output logic                  r0,
    input  logic                  a0,
    output logic [idx_w(N)-1:0]   gnt_id,
    output logic                  busy,
    output logic                  err
);

    localparam int IW = idx_w(N);

    logic [N-1:0]  r_s;
    logic          a0_s;
    logic          a0_q;
    logic          a0_rise;
    logic          a0_fall;

    state_t        state, state_nx;
    logic [IW-1:0] ptr, ptr_nx;
    logic [IW-1:0] gnt_nx;
    logic [N-1:0]  a_nx;
    logic          r0_nx;
    logic          err_nx;
    // Requester withdrew before the resource acknowledged; the handshake
    // then finishes without ever raising a[g].
    logic          wd, wd_nx;

    logic [N-1:0]  r_rot;
    logic [IW-1:0] win;
    int            sum;

    // Synchronizer stage boundary: every asynchronous input enters here
    for (genvar i = 0; i < N; i++) begin : g_sync_r
        sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
            .clk  (clk),
            .rstn (rstn),
            .d    (r[i]),
            .q    (r_s[i])
        );
    end

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_a0 (
        .clk  (clk),
        .rstn (rstn),
        .d    (a0),
        .q    (a0_s)
    );

    assign a0_rise = a0_s & ~a0_q;
    assign a0_fall = ~a0_s & a0_q;

    // Round-robin pick: rotate requests so bit 0 is the ptr channel, then the
    // lowest set bit of the rotated vector is the winner. The descending loop
    // lets the lowest set position overwrite any higher one.
    always_comb begin
        r_rot = N'({r_s, r_s} >> ptr);
        win   = ptr;
        sum   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (r_rot[k]) begin
                sum = int'(ptr) + k;
                win = IW'((sum >= N) ? (sum - N) : sum);
            end
        end
    end

    always_comb begin
        state_nx = state;
        a_nx     = a;
        r0_nx    = r0;
        gnt_nx   = gnt_id;
        ptr_nx   = ptr;
        err_nx   = err;
        wd_nx    = wd;
        unique case (state)
            ST_IDLE: begin
                if (a0_rise) begin
                    err_nx = 1'b1;
                end
                if (|r_s) begin
                    gnt_nx   = win;
                    r0_nx    = 1'b1;
                    wd_nx    = 1'b0;
                    state_nx = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!r_s[gnt_id]) begin
                    err_nx = 1'b1;
                    wd_nx  = 1'b1;
                end
                if (a0_s) begin
                    if (wd || !r_s[gnt_id]) begin
                        r0_nx    = 1'b0;
                        state_nx = ST_RELEASE;
                    end else begin
                        a_nx         = '0;
                        a_nx[gnt_id] = 1'b1;
                        state_nx     = ST_GRANT;
                    end
                end
            end
            ST_GRANT: begin
                if (a0_fall) begin
                    err_nx = 1'b1;
                end
                if (!r_s[gnt_id]) begin
                    r0_nx    = 1'b0;
                    state_nx = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // Returning to IDLE only; the next grant is evaluated from
                // IDLE on a later edge.
                if (!a0_s) begin
                    a_nx     = '0;
                    ptr_nx   = (gnt_id == IW'(N - 1)) ? '0 : gnt_id + IW'(1);
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // FSM register stage boundary
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= ST_IDLE;
            a      <= '0;
            r0     <= 1'b0;
            gnt_id <= '0;
            ptr    <= '0;
            err    <= 1'b0;
            wd     <= 1'b0;
            a0_q   <= 1'b0;
        end else begin
            state  <= state_nx;
            a      <= a_nx;
            r0     <= r0_nx;
            gnt_id <= gnt_nx;
            ptr    <= ptr_nx;
            err    <= err_nx;
            wd     <= wd_nx;
            a0_q   <= a0_s;
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_arbiter_rr4_4ph.sv
module tb_arbiter_rr4_4ph;

    localparam int N  = 4;
    localparam int IW = 2;

    logic          clk  = 1'b0;
    logic          rstn = 1'b0;
    logic [N-1:0]  r;
    logic [N-1:0]  r_man  = '0;
    logic [N-1:0]  r_auto = '0;
    logic [N-1:0]  en     = '0;
    logic [N-1:0]  a;
    logic          r0;
    logic          a0 = 1'b0;
    logic [IW-1:0] gnt_id;
    logic          busy;
    logic          err;

    int a0_dly = 12;
    int errors = 0;
    int checks = 0;
    int win_q[$];

    assign r = r_man | r_auto;

    always #5 clk = ~clk;

    // Resource: a0 follows r0 after a fixed delay.
    always @(r0) begin
        #(a0_dly) a0 = r0;
    end

    // Well-behaved requesters: drop r after ack, re-raise after ack falls.
    always @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            r_auto = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (r_auto[i] && a[i]) r_auto[i] = 1'b0;
                else if (!r_auto[i] && !a[i] && en[i]) r_auto[i] = 1'b1;
            end
        end
    end

    arbiter_rr4_4ph #(.N(N), .SYNC_STAGES(2)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .r      (r),
        .a      (a),
        .r0     (r0),
        .a0     (a0),
        .gnt_id (gnt_id),
        .busy   (busy),
        .err    (err)
    );

    // ---------------- behavioural model ----------------
    // phase 0 idle, 1 waiting for resource ack, 2 requester granted,
    // 3 waiting for resource release
    int            m_phase = 0;
    int            m_g     = 0;
    int            m_ptr   = 0;
    logic          m_bad = 1'b0, m_err = 1'b0, m_granted = 1'b0;
    logic [N-1:0]  m_r1 = '0, m_r2 = '0;
    logic          m_a1 = 1'b0, m_a2 = 1'b0, m_a_prev = 1'b0;

    function automatic int pick(input logic [N-1:0] v, input int p);
        logic [IW-1:0] ix;
        for (int k = 0; k < N; k++) begin
            ix = IW'((p + k) % N);
            if (v[ix]) return (p + k) % N;
        end
        return p;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_phase = 0; m_g = 0; m_ptr = 0;
            m_bad = 1'b0; m_err = 1'b0; m_granted = 1'b0;
            m_r1 = '0; m_r2 = '0; m_a1 = 1'b0; m_a2 = 1'b0; m_a_prev = 1'b0;
        end else begin
            case (m_phase)
                0: begin
                    if (m_a2 && !m_a_prev) m_err = 1'b1;
                    if (m_r2 != '0) begin
                        m_g = pick(m_r2, m_ptr);
                        m_bad = 1'b0;
                        m_phase = 1;
                    end
                end
                1: begin
                    if (!m_r2[m_g]) begin m_err = 1'b1; m_bad = 1'b1; end
                    if (m_a2) begin
                        if (m_bad) m_phase = 3;
                        else begin m_phase = 2; m_granted = 1'b1; end
                    end
                end
                2: begin
                    if (!m_a2 && m_a_prev) m_err = 1'b1;
                    if (!m_r2[m_g]) m_phase = 3;
                end
                default: begin
                    if (!m_a2) begin
                        m_ptr = (m_g + 1) % N;
                        m_granted = 1'b0;
                        m_phase = 0;
                    end
                end
            endcase
            m_a_prev = m_a2;
            m_r2 = m_r1; m_r1 = r;
            m_a2 = m_a1; m_a1 = a0;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        r_man = '0;
        en    = '0;
        @(negedge clk);
        #2 rstn = 1'b0;
        #1 chk("reset_outputs_async", int'({a, r0, gnt_id, busy, err}), 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        win_q.delete();
    endtask

    task automatic wait_a(input int i, input logic lvl, input string nm);
        int n = 0;
        while (a[i] !== lvl && n < 400) begin @(negedge clk); n++; end
        chk(nm, int'(a[i]), int'(lvl));
    endtask

    task automatic wait_r0(input logic lvl, input string nm);
        int n = 0;
        while (r0 !== lvl && n < 400) begin @(negedge clk); n++; end
        chk(nm, int'(r0), int'(lvl));
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((busy !== 1'b0 || a0 !== 1'b0 || r !== '0) && n < 400) begin
            @(negedge clk); n++;
        end
        chk(nm, int'(busy), 0);
    endtask

    task automatic wait_wins(input int cnt, input string nm);
        int n = 0;
        while (win_q.size() < cnt && n < 2000) begin @(negedge clk); n++; end
        chk(nm, win_q.size() >= cnt ? cnt : win_q.size(), cnt);
    endtask

    initial begin
        int n;
        logic busy_ok;
        int exp_rr[5]  = '{0, 1, 2, 3, 0};
        int exp_alt[8] = '{0, 2, 0, 2, 0, 2, 0, 2};

        // Per-cycle comparison against the model and one-hot check.
        fork
            begin : cmp
                logic [N-1:0] prev_a = '0;
                logic [N+IW+2:0] exp_v, act_v;
                logic [N-1:0] exp_a;
                forever begin
                    @(negedge clk);
                    exp_a = m_granted ? (N'(1) << m_g) : '0;
                    exp_v = {exp_a, (m_phase == 1 || m_phase == 2), IW'(m_g),
                             (m_phase != 0), m_err};
                    act_v = {a, r0, gnt_id, busy, err};
                    checks++;
                    if (act_v !== exp_v) begin
                        errors++;
                        $display("FAIL model_cmp @%0t: actual a=%b r0=%b gnt=%0d busy=%b err=%b required a=%b r0=%b gnt=%0d busy=%b err=%b",
                                 $time, a, r0, gnt_id, busy, err, exp_a,
                                 (m_phase == 1 || m_phase == 2), m_g, (m_phase != 0), m_err);
                    end
                    checks++;
                    if ($countones(a) > 1) begin
                        errors++;
                        $display("FAIL onehot_a: actual a=%b required at most one bit", a);
                    end
                    if (a != '0 && prev_a == '0) win_q.push_back(int'(gnt_id));
                    prev_a = a;
                end
            end
            begin : watchdog
                #1000000;
                $display("FAIL watchdog: actual=timeout required=completion");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Single requester
        do_reset();
        @(negedge clk) r_man = 4'b0001;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (r0 !== 1'b1 && n < 20);
        chk("s1_r0_latency_edges", n, 3);
        wait_a(0, 1'b1, "s1_a0_up");
        chk("s1_gnt_id", int'(gnt_id), 0);
        @(negedge clk) r_man = '0;
        wait_a(0, 1'b0, "s1_a0_down");
        wait_idle("s1_idle");
        chk("s1_err", int'(err), 0);

        // Simultaneous requests, round-robin order
        do_reset();
        @(negedge clk) en = 4'b1111;
        wait_wins(5, "s2_win_count");
        en = '0;
        for (int i = 0; i < 5; i++)
            chk($sformatf("s2_win%0d", i), (i < win_q.size()) ? win_q[i] : -1, exp_rr[i]);
        wait_idle("s2_idle");

        // Fairness between r[0] and r[2]
        do_reset();
        @(negedge clk) en = 4'b0101;
        wait_wins(8, "s3_win_count");
        en = '0;
        for (int i = 0; i < 8; i++)
            chk($sformatf("s3_win%0d", i), (i < win_q.size()) ? win_q[i] : -1, exp_alt[i]);
        wait_idle("s3_idle");
        chk("s3_err", int'(err), 0);

        // Protocol error: r[1] withdrawn while waiting for the resource
        do_reset();
        @(negedge clk) r_man = 4'b0010;
        wait_r0(1'b1, "s4_r0_up");
        r_man = '0;
        wait_r0(1'b0, "s4_r0_down");
        wait_idle("s4_idle");
        chk("s4_err_set", int'(err), 1);
        chk("s4_no_grant", win_q.size(), 0);
        repeat (5) @(negedge clk);
        chk("s4_err_sticky", int'(err), 1);

        // Reset mid-transaction, pending r[3] served first afterwards
        do_reset();
        @(negedge clk) r_man = 4'b0100;
        wait_a(2, 1'b1, "s5_a2_up");
        @(negedge clk) r_man = 4'b1100;
        #2 rstn = 1'b0;
        #1 chk("s5_async_clear", int'({a, r0, busy, err}), 0);
        r_man = 4'b1000;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        win_q.delete();
        wait_wins(1, "s5_win_count");
        chk("s5_first_win", (win_q.size() > 0) ? win_q[0] : -1, 3);
        wait_a(3, 1'b1, "s5_a3_up");
        @(negedge clk) r_man = '0;
        wait_idle("s5_idle");

        // Slow resource
        a0_dly = 303;
        do_reset();
        @(negedge clk) r_man = 4'b0010;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (r0 !== 1'b1 && n < 20);
        n = 0;
        busy_ok = 1'b1;
        do begin
            @(posedge clk); #1; n++;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end while (a[1] !== 1'b1 && n < 60);
        chk("s6_grant_edges", n, 33);
        chk("s6_busy_held", int'(busy_ok), 1);
        @(negedge clk) r_man = '0;
        wait_idle("s6_idle");
        chk("s6_err", int'(err), 0);
        a0_dly = 12;

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
